// File: rtl/vco_fp_mc.sv
// vco_fp_mc: N_CH harmonic oscillators advanced by explicit Euler steps.
// Channels are swept one after another, five cycles each, through one registered multiplier.
module vco_fp_mc #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned XW   = 14,
    parameter int unsigned WW   = 17,
    parameter int unsigned DTW  = 20,
    parameter int          X0   = 6471
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step,
    input  logic [DTW-1:0]       dt,
    input  logic [N_CH*WW-1:0]   w,
    input  logic [N_CH-1:0]      ch_en,
    output logic                 busy,
    output logic                 done,
    output logic [N_CH*XW-1:0]   out,
    output logic [N_CH-1:0]      zc,
    output logic                 overrun,
    output logic                 sat
);

    localparam int unsigned CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned MAW = ((DTW > WW) ? DTW : WW) + 1;
    localparam int unsigned MBW = ((WW > XW + 2) ? WW : XW + 2) + 1;
    localparam int unsigned PW  = MAW + MBW;
    localparam int unsigned SW  = XW + 2;
    localparam logic signed [SW-1:0] SMAX = SW'((1 << (XW - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);

    typedef enum logic [2:0] {StIdle, StMw2, StMa, StMv, StMx, StWr} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [DTW-1:0]        dt_q, dt_d;
    logic [N_CH-1:0]       en_q, en_d, zc_q, zc_d;
    logic signed [PW-1:0]  prod_q, prod_d;
    logic signed [SW-1:0]  dv_q, dv_d;
    logic                  wz_q, wz_d;
    logic signed [XW-1:0]  x_q [N_CH];
    logic signed [XW-1:0]  x_d [N_CH];
    logic signed [XW-1:0]  v_q [N_CH];
    logic signed [XW-1:0]  v_d [N_CH];
    logic                  done_q, done_d, overrun_q, overrun_d, sat_q, sat_d;

    logic [WW-1:0]         w_cur;
    logic signed [XW-1:0]  x_cur, v_cur, x_new, v_new;
    logic signed [MAW-1:0] mul_a;
    logic signed [MBW-1:0] mul_b;
    logic signed [PW-1:0]  neg_prod, a_full, d_full;
    logic signed [SW-1:0]  x_sum, v_sum;
    logic                  x_clamp, v_clamp;
    logic                  unused_bits;

    assign unused_bits = ^{a_full[PW-1:MBW], d_full[PW-1:SW]};

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        dt_d      = dt_q;
        en_d      = en_q;
        zc_d      = zc_q;
        dv_d      = dv_q;
        wz_d      = wz_q;
        x_d       = x_q;
        v_d       = v_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        sat_d     = sat_q;
        mul_a     = '0;
        mul_b     = '0;

        w_cur    = w[ch_q*WW +: WW];
        x_cur    = x_q[ch_q];
        v_cur    = v_q[ch_q];
        neg_prod = -prod_q;
        a_full   = neg_prod >>> WW;
        d_full   = prod_q >>> DTW;

        // d_full holds dx in WR; dv was captured from it one cycle earlier
        x_sum   = {{(SW-XW){x_cur[XW-1]}}, x_cur} + d_full[SW-1:0];
        v_sum   = {{(SW-XW){v_cur[XW-1]}}, v_cur} + dv_q;
        x_clamp = (x_sum > SMAX) || (x_sum < SMIN);
        v_clamp = (v_sum > SMAX) || (v_sum < SMIN);
        x_new   = (x_sum > SMAX) ? SMAX[XW-1:0] : (x_sum < SMIN) ? SMIN[XW-1:0] : x_sum[XW-1:0];
        v_new   = (v_sum > SMAX) ? SMAX[XW-1:0] : (v_sum < SMIN) ? SMIN[XW-1:0] : v_sum[XW-1:0];

        unique case (state_q)
            StIdle: begin
                if (step) begin
                    state_d = StMw2;
                    ch_d    = '0;
                    dt_d    = dt;
                    en_d    = ch_en;
                    zc_d    = '0;
                end
            end
            StMw2: begin
                mul_a   = {{(MAW-WW){1'b0}}, w_cur};
                mul_b   = {{(MBW-WW){1'b0}}, w_cur};
                wz_d    = (w_cur == '0);
                state_d = StMa;
            end
            StMa: begin
                mul_a   = {{(MAW-WW){1'b0}}, prod_q[WW +: WW]};
                mul_b   = {{(MBW-XW){x_cur[XW-1]}}, x_cur};
                state_d = StMv;
            end
            StMv: begin
                mul_a   = {{(MAW-DTW){1'b0}}, dt_q};
                mul_b   = a_full[MBW-1:0];
                state_d = StMx;
            end
            StMx: begin
                dv_d    = d_full[SW-1:0];
                mul_a   = {{(MAW-DTW){1'b0}}, dt_q};
                mul_b   = {{(MBW-XW){v_cur[XW-1]}}, v_cur};
                state_d = StWr;
            end
            StWr: begin
                // a zero frequency word freezes the channel entirely, v included
                if (en_q[ch_q] && !wz_q) begin
                    x_d[ch_q] = x_new;
                    v_d[ch_q] = v_new;
                    sat_d     = sat_q | x_clamp | v_clamp;
                    if (x_cur[XW-1] && !x_new[XW-1]) zc_d[ch_q] = 1'b1;
                end
                if (ch_q == CW'(N_CH - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = StMw2;
                end
            end
            default: state_d = StIdle;
        endcase

        if (step && (state_q != StIdle)) overrun_d = 1'b1;
        prod_d = mul_a * mul_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            dt_q      <= '0;
            en_q      <= '0;
            zc_q      <= '0;
            prod_q    <= '0;
            dv_q      <= '0;
            wz_q      <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            sat_q     <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                x_q[i] <= XW'(X0);
                v_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            dt_q      <= dt_d;
            en_q      <= en_d;
            zc_q      <= zc_d;
            prod_q    <= prod_d;
            dv_q      <= dv_d;
            wz_q      <= wz_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            sat_q     <= sat_d;
            x_q       <= x_d;
            v_q       <= v_d;
        end
    end

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_out
        assign out[i*XW +: XW] = x_q[i];
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign zc      = zc_q;
    assign overrun = overrun_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_vco_fp_mc.sv
// Scoreboard bench for vco_fp_mc: random steps against an arithmetic Euler model.
module tb_vco_fp_mc;

    localparam int N_CH = 4;
    localparam int XW   = 14;
    localparam int WW   = 17;
    localparam int DTW  = 20;
    localparam int X0   = 6471;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                step = 1'b0;
    logic [DTW-1:0]      dt = '0;
    logic [N_CH*WW-1:0]  w = '0;
    logic [N_CH-1:0]     ch_en = '0;
    logic                busy, done, overrun, sat;
    logic [N_CH*XW-1:0]  out;
    logic [N_CH-1:0]     zc;

    vco_fp_mc #(.N_CH(N_CH), .XW(XW), .WW(WW), .DTW(DTW), .X0(X0)) dut (
        .clk(clk), .reset(reset), .step(step), .dt(dt), .w(w), .ch_en(ch_en),
        .busy(busy), .done(done), .out(out), .zc(zc), .overrun(overrun), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CH*XW-1:0] xo;
        logic [N_CH-1:0]    zc;
        logic               sat;
        int                 acc;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     done_cnt = 0;
    longint mx[N_CH];
    longint mv[N_CH];
    bit     msat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint getx(input int c);
        logic signed [XW-1:0] t;
        t = out[c*XW +: XW];
        return longint'(t);
    endfunction

    function automatic longint clip(input longint s);
        if (s > 8191) begin msat = 1'b1; return 8191; end
        if (s < -8192) begin msat = 1'b1; return -8192; end
        return s;
    endfunction

    // Reference: one Euler step of x'' = -w^2 x per enabled channel, plain integer arithmetic.
    function automatic exp_t model_step(input logic [DTW-1:0] d, input logic [N_CH*WW-1:0] ww,
                                        input logic [N_CH-1:0] en);
        exp_t   e;
        longint wc, w2, a, dv, dx, nx, nv, dtl;
        logic signed [XW-1:0] t;
        dtl = longint'(d);
        e.zc = '0;
        for (int c = 0; c < N_CH; c++) begin
            wc = longint'(ww[c*WW +: WW]);
            if (en[c] && wc != 0) begin
                w2 = (wc * wc) >>> WW;
                a  = (-(w2 * mx[c])) >>> WW;
                dv = (dtl * a) >>> DTW;
                dx = (dtl * mv[c]) >>> DTW;
                nv = clip(mv[c] + dv);
                nx = clip(mx[c] + dx);
                if (mx[c] < 0 && nx >= 0) e.zc[c] = 1'b1;
                mv[c] = nv;
                mx[c] = nx;
            end
            t = XW'(mx[c]);
            e.xo[c*XW +: XW] = t;
        end
        e.sat = msat;
        e.acc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            exp_t e;
            logic signed [XW-1:0] t;
            done_cnt++;
            chk("done_has_expect", longint'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("latency", longint'(cyc - e.acc), 20);
                for (int c = 0; c < N_CH; c++) begin
                    t = e.xo[c*XW +: XW];
                    chk($sformatf("out_ch%0d", c), getx(c), longint'(t));
                end
                chk("zc", longint'(zc), longint'(e.zc));
                chk("sat", longint'(sat), longint'(e.sat));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (busy !== 1'b0) chk("wait_idle_timeout", longint'(busy), 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            chk("drain_timeout", longint'(q.size()), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue_step(input logic [DTW-1:0] d, input logic [N_CH*WW-1:0] ww,
                              input logic [N_CH-1:0] en, input bit expect_done);
        exp_t e;
        wait_idle();
        dt = d; w = ww; ch_en = en; step = 1'b1;
        if (expect_done) begin
            e = model_step(d, ww, en);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; step = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q.delete();
        msat = 1'b0;
        for (int c = 0; c < N_CH; c++) begin mx[c] = X0; mv[c] = 0; end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_zc"}, longint'(zc), 0);
        chk({tag, "_overrun"}, longint'(overrun), 0);
        chk({tag, "_sat"}, longint'(sat), 0);
        for (int c = 0; c < N_CH; c++) chk($sformatf("%s_x%0d", tag, c), getx(c), X0);
    endtask

    function automatic logic [N_CH*WW-1:0] rep_w(input logic [WW-1:0] v);
        return {N_CH{v}};
    endfunction

    function automatic logic [N_CH*WW-1:0] rand_w();
        logic [N_CH*WW-1:0] r;
        for (int c = 0; c < N_CH; c++)
            r[c*WW +: WW] = ($urandom_range(0, 7) == 0) ? '0 : WW'($urandom_range(0, 131071));
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        do_reset();
        check_reset_state("reset");

        // Two half-steps at w=0.5: x holds then drops to 6066
        issue_step(20'd524288, rep_w(17'd65536), 4'hF, 1'b1);
        wait_drain();
        for (int c = 0; c < N_CH; c++) chk($sformatf("step1_x%0d", c), getx(c), 6471);
        issue_step(20'd524288, rep_w(17'd65536), 4'hF, 1'b1);
        wait_drain();
        for (int c = 0; c < N_CH; c++) chk($sformatf("step2_x%0d", c), getx(c), 6066);
        chk("step2_sat", longint'(sat), 0);
        chk("step2_zc", longint'(zc), 0);

        // Zero frequency word holds the channel at maximum dt
        do_reset();
        for (int i = 0; i < 10; i++) begin
            issue_step(20'd1048575, rep_w(17'd0), 4'hF, 1'b1);
            wait_drain();
            chk("w0_x0", getx(0), 6471);
        end
        chk("w0_sat", longint'(sat), 0);

        // Partial enable mask
        do_reset();
        for (int i = 0; i < 2; i++) issue_step(20'd524288, rep_w(17'd65536), 4'b0101, 1'b1);
        wait_drain();
        chk("en_x0", getx(0), 6066);
        chk("en_x1", getx(1), 6471);
        chk("en_x2", getx(2), 6066);
        chk("en_x3", getx(3), 6471);

        // Step during a sweep is dropped and flagged
        do_reset();
        d0 = done_cnt;
        issue_step(20'd300000, rand_w(), 4'hF, 1'b1);
        repeat (2) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_drain();
        repeat (25) @(negedge clk);
        chk("overrun_flag", longint'(overrun), 1);
        chk("overrun_done_count", longint'(done_cnt - d0), 1);

        // Reset seven cycles into a sweep aborts it
        do_reset();
        d0 = done_cnt;
        issue_step(20'd524288, rep_w(17'd65536), 4'hF, 1'b0);
        repeat (6) @(negedge clk);
        do_reset();
        check_reset_state("abort");
        issue_step(20'd524288, rep_w(17'd65536), 4'hF, 1'b1);
        wait_drain();
        chk("abort_done_count", longint'(done_cnt - d0), 1);

        // Random steps
        do_reset();
        for (int i = 0; i < 40; i++) begin
            issue_step(DTW'($urandom_range(0, 1048575)), rand_w(), N_CH'($urandom_range(0, 15)),
                       1'b1);
        end
        wait_drain();

        // Long run at full frequency and timestep: growth, saturation and crossings
        do_reset();
        for (int i = 0; i < 80; i++) issue_step(20'd1048575, rep_w(17'd131071), 4'hF, 1'b1);
        wait_drain();
        chk("long_sat", longint'(sat), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
